// File: rtl/move_selector.sv
// Picks the best legal column from the network's output activations and hands it off over valid/ack.
// Optional centre-out scan order (nearest-centre tie-break) is enabled by defining MOVE_SEL_CENTER_PREF_EN.
module move_selector #(
    parameter int NUM_COLS    = 7,
    parameter int SCORE_WIDTH = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fp_done,
    input  logic signed [SCORE_WIDTH-1:0] scores [0:NUM_COLS-1],
    input  logic [NUM_COLS-1:0]           col_full,
    input  logic                          move_ack,
    output logic                          move_valid,
    output logic [$clog2(NUM_COLS)-1:0]   move_col,
    output logic                          no_legal_move,
    output logic signed [SCORE_WIDTH-1:0] best_score,
    output logic                          nn_clear,
    output logic [2:0]                    state_dbg
);
    localparam int IDX_W = $clog2(NUM_COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        PRESENT = 3'd2,
        CLEAR   = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic [IDX_W-1:0]                best_col;
    logic [IDX_W-1:0]                cur_col;
    logic [IDX_W-1:0]                nxt_col;
    logic                            found;
    logic                            nxt_found;
    logic                            take;
    logic signed [SCORE_WIDTH-1:0]   best_q;
    logic signed [SCORE_WIDTH-1:0]   nxt_best;
    logic signed [SCORE_WIDTH-1:0]   score_q [0:NUM_COLS-1];
    logic [NUM_COLS-1:0]             full_q;

    assign state_dbg = state;

    // Maps scan step k to the column evaluated at that step; ties favour earlier steps.
    function automatic logic [IDX_W-1:0] scan_col(input logic [IDX_W-1:0] k);
`ifdef MOVE_SEL_CENTER_PREF_EN
        int center;
        int off;
        center = NUM_COLS / 2;
        off    = (int'(k) + 1) / 2;
        if (k[0]) return IDX_W'(center - off);
        else      return IDX_W'(center + off);
`else
        return k;
`endif
    endfunction

    always_comb begin
        cur_col   = scan_col(idx);
        take      = !full_q[cur_col] && (!found || (score_q[cur_col] > best_q));
        nxt_found = found;
        nxt_col   = best_col;
        nxt_best  = best_q;
        if (take) begin
            nxt_found = 1'b1;
            nxt_col   = cur_col;
            nxt_best  = score_q[cur_col];
        end
    end

    // Handshake: move_valid holds with stable move_col/best_score/no_legal_move until an edge samples move_ack=1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            found         <= 1'b0;
            best_q        <= '0;
            best_col      <= '0;
            full_q        <= '0;
            move_valid    <= 1'b0;
            move_col      <= '0;
            no_legal_move <= 1'b0;
            best_score    <= '0;
            nn_clear      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fp_done) begin
                        score_q <= scores;
                        full_q  <= col_full;
                        found   <= 1'b0;
                        idx     <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    best_q   <= nxt_best;
                    best_col <= nxt_col;
                    found    <= nxt_found;
                    idx      <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx           <= '0;
                        state         <= PRESENT;
                        move_valid    <= 1'b1;
                        no_legal_move <= !nxt_found;
                        move_col      <= nxt_found ? nxt_col : '0;
                        best_score    <= nxt_found ? nxt_best : '0;
                    end
                end
                PRESENT: begin
                    if (move_ack) begin
                        move_valid    <= 1'b0;
                        move_col      <= '0;
                        best_score    <= '0;
                        no_legal_move <= 1'b0;
                        nn_clear      <= 1'b1;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    nn_clear <= 1'b0;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    // Hold off until the network has really dropped fp_done.
                    if (!fp_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_selector.sv
// Directed and random bench for move_selector: expected moves are queued at launch and
// compared when move_valid rises, along with handshake, clear pulse and drain behaviour.
module tb_move_selector;
    localparam int NC = 7;
    localparam int SW = 14;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic                 clk;
    logic                 rst;
    logic                 fp_done;
    logic signed [SW-1:0] scores [0:NC-1];
    logic [NC-1:0]        col_full;
    logic                 move_ack;
    logic                 move_valid;
    logic [2:0]           move_col;
    logic                 no_legal_move;
    logic signed [SW-1:0] best_score;
    logic                 nn_clear;
    logic [2:0]           state_dbg;

    logic [17:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    move_selector #(.NUM_COLS(NC), .SCORE_WIDTH(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fp_done       (fp_done),
        .scores        (scores),
        .col_full      (col_full),
        .move_ack      (move_ack),
        .move_valid    (move_valid),
        .move_col      (move_col),
        .no_legal_move (no_legal_move),
        .best_score    (best_score),
        .nn_clear      (nn_clear),
        .state_dbg     (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out, observed no end, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_scores(input int a, input int b, input int c, input int d,
                              input int e, input int f, input int g);
        scores[0] = SW'(a); scores[1] = SW'(b); scores[2] = SW'(c); scores[3] = SW'(d);
        scores[4] = SW'(e); scores[5] = SW'(f); scores[6] = SW'(g);
    endtask

    function automatic logic [17:0] pack_exp(input logic nl, input int col, input int sc);
        return {nl, 3'(col), SW'(sc)};
    endfunction

    // Reference: walk the priority order, keep the first strictly-greater legal score.
    function automatic logic [17:0] ref_move();
`ifdef MOVE_SEL_CENTER_PREF_EN
        int ord[NC] = '{3, 2, 4, 1, 5, 0, 6};
`else
        int ord[NC] = '{0, 1, 2, 3, 4, 5, 6};
`endif
        logic found = 1'b0;
        int best_c = 0;
        logic signed [SW-1:0] b = '0;
        for (int k = 0; k < NC; k++) begin
            if (!col_full[ord[k]] && (!found || scores[ord[k]] > b)) begin
                found  = 1'b1;
                b      = scores[ord[k]];
                best_c = ord[k];
            end
        end
        return found ? {1'b0, 3'(best_c), b} : {1'b1, 3'b0, {SW{1'b0}}};
    endfunction

    task automatic launch();
        @(negedge clk);
        fp_done = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_move(input int hold);
        int lat;
        logic [17:0] exp;
        logic [17:0] obs;
        for (int i = 0; i < NC; i++) scores[i] = SW'($urandom_range(16383));
        col_full = NC'($urandom_range(127));
        lat = 0;
        while (move_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 7);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        obs = {no_legal_move, move_col, best_score};
        check("result", obs, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) check("held", {move_valid, no_legal_move, move_col, best_score}, {1'b1, exp});
        @(negedge clk);
        move_ack = 1'b1;
        @(posedge clk);
        #1;
        check("clear_start", {move_valid, nn_clear, no_legal_move, move_col, best_score},
              {1'b0, 1'b1, 18'b0});
        @(negedge clk);
        move_ack = 1'b0;
        @(posedge clk);
        #1;
        check("clear_end", {nn_clear, state_dbg}, {1'b0, S_DRAIN});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("stale_fp_done", {move_valid, nn_clear, state_dbg}, {1'b0, 1'b0, S_DRAIN});
        @(negedge clk);
        fp_done = 1'b0;
        @(posedge clk);
        #1;
        check("drain_idle", state_dbg, S_IDLE);
    endtask

    initial begin
        rst = 1'b0; fp_done = 1'b0; move_ack = 1'b0; col_full = '0;
        set_scores(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset", {move_valid, move_col, no_legal_move, best_score, nn_clear, state_dbg}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic selection with ack held off for a few cycles
        set_scores(10, -3, 40, 5, 120, 7, 0); col_full = 7'b0000000;
        exp_q.push_back(pack_exp(1'b0, 4, 120));
        launch();
        finish_move(3);

        // Largest score sits in a full column
        set_scores(10, -3, 40, 5, 120, 7, 0); col_full = 7'b0010000;
        exp_q.push_back(pack_exp(1'b0, 2, 40));
        launch();
        finish_move(1);

        // Tie between columns 0 and 4
        set_scores(50, 0, 0, 0, 50, 0, 0); col_full = 7'b0000000;
`ifdef MOVE_SEL_CENTER_PREF_EN
        exp_q.push_back(pack_exp(1'b0, 4, 50));
`else
        exp_q.push_back(pack_exp(1'b0, 0, 50));
`endif
        launch();
        finish_move(0);

        // Negative scores, ack already high during the scan
        set_scores(-8192, -8192, -8192, -8192, -8192, -8192, -1); col_full = 7'b0000000;
        exp_q.push_back(pack_exp(1'b0, 6, -1));
        move_ack = 1'b1;
        launch();
        finish_move(0);

        // Every column full
        set_scores(1, 2, 3, 4, 5, 6, 7); col_full = 7'b1111111;
        exp_q.push_back(pack_exp(1'b1, 0, 0));
        launch();
        finish_move(2);

        // Reset on the third scan edge, then recapture from the still-high fp_done
        set_scores(10, -3, 40, 5, 120, 7, 0); col_full = 7'b0010000;
        launch();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", {move_valid, move_col, no_legal_move, best_score, nn_clear, state_dbg}, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(pack_exp(1'b0, 2, 40));
        @(posedge clk);
        #1;
        finish_move(1);

        // Random patterns
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NC; i++) scores[i] = SW'($urandom_range(16383));
            col_full = NC'($urandom_range(127));
            exp_q.push_back(ref_move());
            launch();
            finish_move(int'($urandom_range(2)));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/move_selector.md
Name: move_selector

Overview:
- Downstream consumer of the neural-network forward pass.
- Waits for `fp_done`, then latches the 7 signed output activations (14-bit, 3.5-style fixed point) and the board's column-full mask.
- Scans the columns sequentially, one per cycle, and selects the highest-scoring legal column.
- Presents the chosen move over a valid/ack handshake, then pulses `nn_clear` to return the network to idle for the next inference.

Parameters:
- NUM_COLS, 7, number of board columns / network outputs scored.
- SCORE_WIDTH, 14, width of each signed activation.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- fp_done  input  1  network forward pass complete; level, held until the network is cleared.
- scores  input  NUM_COLS x SCORE_WIDTH (signed, unpacked [0:NUM_COLS-1])  network output activations.
- col_full  input  NUM_COLS  bit c = 1 means column c is illegal.
- move_ack  input  1  consumer accepts the presented move.
- move_valid  output  1  move_col, no_legal_move and best_score are valid.
- move_col  output  $clog2(NUM_COLS)  selected column index.
- no_legal_move  output  1  all columns full; move_col = 0.
- best_score  output  SCORE_WIDTH signed  score of the selected column; 0 if none.
- nn_clear  output  1  one-cycle active-high pulse to reset the network.

Behaviour:
- Reset (rst=0 at an edge) forces:
  - state IDLE, scan index 0, found flag 0;
  - all outputs 0: move_valid, move_col, no_legal_move, best_score, nn_clear.
- Reset takes priority in every state, including mid-scan; partial results are discarded.
- States are IDLE, SCAN, PRESENT, CLEAR, DRAIN.
- IDLE:
  - On an edge with fp_done=1, capture scores[] and col_full into internal registers, clear the found flag, set idx=0, go to SCAN.
  - Inputs changing after capture have no effect.
- SCAN (exactly NUM_COLS cycles):
  - Each edge evaluates column c = order[idx]; default order is 0..NUM_COLS-1.
  - If c is legal and (found=0 or score[c] > best, signed strict compare): best <= score[c], col <= c, found <= 1.
  - Ties keep the earlier column in scan order.
  - idx increments each edge. On the edge processing idx = NUM_COLS-1, go to PRESENT.
- Latency: move_valid rises NUM_COLS edges after the capture edge (7 for default params).
- PRESENT:
  - move_valid=1.
  - move_col and best_score show the selected column and its score.
  - no_legal_move = ~found; if found=0, move_col=0 and best_score=0.
  - Outputs are held stable until an edge samples move_ack=1, then go to CLEAR.
  - move_ack may already be high on the first PRESENT cycle (accepted at the next edge).
- CLEAR: one cycle; move_valid=0, nn_clear=1; then go to DRAIN.
- DRAIN: wait until fp_done=0, then go to IDLE. This prevents re-triggering on a stale fp_done.
- fp_done is ignored outside IDLE; move_ack is ignored outside PRESENT.
- move_col, best_score and no_legal_move return to 0 when leaving PRESENT.
- No arithmetic other than signed comparison; no widening.

Optional Feature:
- Macro: MOVE_SEL_CENTER_PREF_EN.
- When defined:
  - Scan order is centre-out: 3,2,4,1,5,0,6 (general form: centre, then alternating -1/+1 offsets).
  - Ties resolve toward the column earliest in that order, i.e. nearest the centre.
- When undefined: scan order is 0..NUM_COLS-1 and ties resolve to the lowest index.
- Latency is identical in both builds.

Test Plan:
- Selection and handshake:
  - Stimulus: scores={10,-3,40,5,120,7,0}, col_full=0, fp_done high at edge E0.
  - Response: move_valid rises after E7 with move_col=4, best_score=120, no_legal_move=0; held while move_ack=0.
  - Then move_ack=1 → next cycle nn_clear=1 for exactly one cycle; fp_done drops → IDLE.
- Illegal maximum:
  - Stimulus: same scores, col_full=7'b0010000 (col 4 full).
  - Response: move_col=2, best_score=40.
- Tie-break:
  - Stimulus: scores={50,0,0,0,50,0,0}, col_full=0.
  - Response: default build move_col=0; with MOVE_SEL_CENTER_PREF_EN, move_col=4.
- Negative scores:
  - Stimulus: all scores -8192 except col 6 = -1.
  - Response: move_col=6, best_score=-1 (signed compare verified).
- No legal move:
  - Stimulus: col_full=7'b1111111.
  - Response: move_valid=1, no_legal_move=1, move_col=0, best_score=0; the ack/clear sequence still completes.
- Reset mid-operation:
  - Stimulus: rst=0 at the 3rd SCAN edge with fp_done still high.
  - Response: all outputs 0, state IDLE.
  - After rst=1, the next edge re-captures (fp_done still high) and produces the correct move 7 edges later.
- Stale fp_done:
  - Stimulus: keep fp_done=1 through CLEAR and DRAIN.
  - Response: no second move_valid until fp_done is seen low, then high again.
